gpr_scoreboard: RTL and testbench
=================================

# gpr_scoreboard

Issue-side hazard tracker for the general-purpose register set addressed by `GPR_DESTINATION_SELECTOR`. It records each in-flight write (issue, destination) and retires it on write-back. It holds an instruction at issue while any of its source registers, or its destination register, has unresolved writes. It sits between decode and the execute/write-back pipeline, and is the consuming end of the destination selector path.

## Interface
Parameters:
- `MAX_INFLIGHT`, 3: maximum outstanding writes per register. Range 1..7. The counter width is `$clog2(MAX_INFLIGHT+1)`.

Ports:
- `clock`  in  1  single clock for all state
- `reset_n`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  decode presents an instruction
- `issue_ready`  out  1  instruction accepted this cycle (no hazard)
- `issue_destination`  in  4  `GPR_DESTINATION_SELECTOR` of the issuing instruction
- `issue_source_a`  in  4  `GPR_SOURCE_SELECTOR`, operand A
- `issue_source_b`  in  4  `GPR_SOURCE_SELECTOR`, operand B
- `writeback_valid`  in  1  a write retires this cycle
- `writeback_destination`  in  4  `GPR_DESTINATION_SELECTOR` being retired
- `flush`  in  1  synchronous clear of all pending state
- `busy`  out  12  per-register pending flag; bit index = selector code, with RA..RBP mapped to bits 8..11
- `underflow_error`  out  1  sticky: write-back retired to a register with zero pending writes

## Operation
- Tracked registers: GPR0..GPR7, RA, RAP, RB, RBP, which are 12 codes. NONE (4'b1111) and the unused codes 4'b1100..4'b1110 are never tracked. They never cause a hazard and never change counters.
- `GPR_SOURCE_SELECTOR` uses the same encoding as the destination selector for the 12 registers. 4'b1110 = IMMEDIATE and 4'b1111 = NONE are both hazard-free.
- Each tracked register has a counter `pending[r]`.
- A hazard exists if any of the following holds:
  - source A is tracked and `pending[A] != 0`
  - source B is tracked and `pending[B] != 0`
  - the destination is tracked and `pending[D] == MAX_INFLIGHT`, which gives saturation back-pressure
- A write-after-write to a register with pending < MAX is allowed, because write-back order is in-order.
- `issue_ready = issue_valid & ~hazard & ~flush`. `issue_ready` is low whenever `issue_valid` is low.
- Accept (`issue_valid & issue_ready`) with a tracked destination: `pending[D]` increments.
- `writeback_valid` with a tracked destination:
  - if `pending[W] != 0`, `pending[W]` decrements
  - if `pending[W] == 0`, the counter holds and `underflow_error` is set
- Accept and write-back to the same register in the same cycle: the counter is unchanged.
- `flush`: all counters go to 0 next cycle, and issue is blocked in the flush cycle. A write-back in the flush cycle is ignored, and `underflow_error` is not affected.
- `underflow_error` clears only on reset.
- `busy[r] = (pending[r] != 0)`, registered view of the counters.

## Timing
- Reset values: all counters 0, `busy` = 12'h000, `underflow_error` = 0. `issue_ready` is combinational from the inputs, so it is 0 while `issue_valid` = 0.
- Reset asserted mid-operation clears state immediately (asynchronously). The first accept is possible in the first cycle after `reset_n` rises.
- `issue_ready` is combinational from the issue inputs, the counters and `flush` (and from the write-back inputs, see Configuration). There are no registered stall cycles of its own.
- A counter update is visible in the cycle after the accept or write-back edge.
- A dependent instruction issues at the earliest in the cycle after the matching write-back (without bypass).

## Configuration
- `GPR_SCOREBOARD_BYPASS_EN` defined:
  - a same-cycle write-back that brings `pending[r]` from 1 to 0 also removes the source hazard on `r` in that cycle
  - a same-cycle write-back to D also relieves saturation on D
  - result: issue proceeds in the write-back cycle
- Macro undefined: hazards use the registered counters only, and `issue_ready` does not depend on the write-back ports.

## Structure
- Shared package `package_gpr_source_selector` holds:
  - the `GPR_SOURCE_SELECTOR` enum: the 12 register codes, IMMEDIATE = 4'b1110, NONE = 4'b1111
  - a function `gpr_index(selector)` that returns 0..11 plus a tracked flag
- `GPR_DESTINATION_SELECTOR` is imported from its existing package.
- One sub-module, `gpr_pending_counter`: a per-register saturating up/down counter with increment, decrement, clear and underflow outputs. It is instantiated 12 times.

## Test plan
- Reset, then issue D=GPR3 with sources NONE -> ready=1; next cycle `busy`=12'h008. Then issue with source A=GPR3 -> ready=0.
- Write-back GPR3 -> the next cycle the source-GPR3 issue has ready=1.
  - With BYPASS_EN: ready=1 already in the write-back cycle.
- Issue D=RB three times with MAX_INFLIGHT=3 -> the fourth issue to RB has ready=0. One write-back releases it.
- Same-cycle accept D=GPR1 and write-back GPR1 with pending=1 -> pending stays 1 and `busy[1]`=1.
- Write-back RAP with pending=0 -> `underflow_error`=1 and stays 1 through flush. Only reset clears it.
- Load 5 pending writes across GPR0, RA and RBP, then assert flush -> `busy`=0 next cycle, issue blocked during the flush cycle. Asserting `reset_n`=0 mid-sequence clears everything asynchronously.

Source files
------------

// File: rtl/gpr_scoreboard_pkg.sv
// rtl/gpr_scoreboard_pkg.sv - GPR destination/source selector encodings and index helper
// Holds package_gpr_destination_selector (destination selector enum) and
// package_gpr_source_selector (source selector enum, register count, gpr_index()).
// Both encodings share codes 0..11 for GPR0..GPR7, RA, RAP, RB, RBP.

package package_gpr_destination_selector;

    typedef enum logic [3:0] {
        DST_GPR0 = 4'd0,
        DST_GPR1 = 4'd1,
        DST_GPR2 = 4'd2,
        DST_GPR3 = 4'd3,
        DST_GPR4 = 4'd4,
        DST_GPR5 = 4'd5,
        DST_GPR6 = 4'd6,
        DST_GPR7 = 4'd7,
        DST_RA   = 4'd8,
        DST_RAP  = 4'd9,
        DST_RB   = 4'd10,
        DST_RBP  = 4'd11,
        DST_NONE = 4'd15
    } GPR_DESTINATION_SELECTOR;

endpackage

package package_gpr_source_selector;

    localparam int GPR_COUNT = 12;

    typedef enum logic [3:0] {
        SRC_GPR0      = 4'd0,
        SRC_GPR1      = 4'd1,
        SRC_GPR2      = 4'd2,
        SRC_GPR3      = 4'd3,
        SRC_GPR4      = 4'd4,
        SRC_GPR5      = 4'd5,
        SRC_GPR6      = 4'd6,
        SRC_GPR7      = 4'd7,
        SRC_RA        = 4'd8,
        SRC_RAP       = 4'd9,
        SRC_RB        = 4'd10,
        SRC_RBP       = 4'd11,
        SRC_IMMEDIATE = 4'd14,
        SRC_NONE      = 4'd15
    } GPR_SOURCE_SELECTOR;

    typedef struct packed {
        logic       tracked;
        logic [3:0] index;
    } gpr_index_t;

    // Untracked codes report index 0 so callers can index per-register
    // vectors without going out of range; the tracked flag masks the result.
    function automatic gpr_index_t gpr_index(input logic [3:0] selector);
        gpr_index_t result;
        result.tracked = (selector < 4'd12);
        result.index   = result.tracked ? selector : 4'd0;
        return result;
    endfunction

endpackage

// File: rtl/gpr_scoreboard_if.sv
// rtl/gpr_scoreboard_if.sv - issue and write-back signal bundle for gpr_scoreboard
// master: decode/pipeline side (drives issue_* and writeback_*, receives issue_ready)
// slave : scoreboard side

interface gpr_scoreboard_if;
    import package_gpr_source_selector::*;
    import package_gpr_destination_selector::*;

    logic                    issue_valid;
    logic                    issue_ready;
    GPR_DESTINATION_SELECTOR issue_destination;
    GPR_SOURCE_SELECTOR      issue_source_a;
    GPR_SOURCE_SELECTOR      issue_source_b;
    logic                    writeback_valid;
    GPR_DESTINATION_SELECTOR writeback_destination;

    modport master (
        output issue_valid,
        input  issue_ready,
        output issue_destination,
        output issue_source_a,
        output issue_source_b,
        output writeback_valid,
        output writeback_destination
    );

    modport slave (
        input  issue_valid,
        output issue_ready,
        input  issue_destination,
        input  issue_source_a,
        input  issue_source_b,
        input  writeback_valid,
        input  writeback_destination
    );

endinterface

// File: rtl/gpr_scoreboard_pending_counter.sv
// rtl/gpr_scoreboard_pending_counter.sv - per-register saturating up/down pending-write counter
// Module gpr_pending_counter.
// Ports: clock, reset_n (async, active-low), clear (sync), inc, dec,
//        count (registered value), underflow (dec seen while count is zero).

module gpr_pending_counter #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          underflow
);

    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Simultaneous inc and dec cancel; the saturation and zero guards only
    // protect the counter, the scoreboard never requests an illegal step.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q != MAX_C) begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign underflow = dec & ~clear & (count_q == '0);

endmodule

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - issue-side hazard tracker for the GPR set
// Ports: clock, reset_n (async, active-low), sb (gpr_scoreboard_if.slave:
//        issue handshake + write-back), flush (sync clear of pending state),
//        busy[11:0] (per-register pending flag), underflow_error (sticky).
// Optional: GPR_SCOREBOARD_BYPASS_EN lets a same-cycle write-back relieve
//           the hazard it resolves.

module gpr_scoreboard
    import package_gpr_source_selector::*;
    import package_gpr_destination_selector::*;
#(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    gpr_scoreboard_if.slave        sb,
    input  logic                   flush,
    output logic [GPR_COUNT-1:0]   busy,
    output logic                   underflow_error
);

    localparam int            CW    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INFLIGHT);

    gpr_index_t src_a;
    gpr_index_t src_b;
    gpr_index_t dst;
    gpr_index_t wbk;

    logic [CW-1:0]        count [GPR_COUNT];
    logic [GPR_COUNT-1:0] nonzero_vec;
    logic [GPR_COUNT-1:0] sat_vec;
    logic [GPR_COUNT-1:0] inc_vec;
    logic [GPR_COUNT-1:0] dec_vec;
    logic [GPR_COUNT-1:0] uf_vec;
    logic                 relieve_a;
    logic                 relieve_b;
    logic                 relieve_d;
    logic                 hazard;
    logic                 accept;
    logic                 underflow_error_q;
    logic                 underflow_error_d;

    assign src_a = gpr_index(sb.issue_source_a);
    assign src_b = gpr_index(sb.issue_source_b);
    assign dst   = gpr_index(sb.issue_destination);
    assign wbk   = gpr_index(sb.writeback_destination);

    always_comb begin
        nonzero_vec = '0;
        sat_vec     = '0;
        for (int r = 0; r < GPR_COUNT; r++) begin
            nonzero_vec[r] = (count[r] != '0);
            sat_vec[r]     = (count[r] == MAX_C);
        end
    end

`ifdef GPR_SCOREBOARD_BYPASS_EN
    logic [GPR_COUNT-1:0] one_vec;
    logic                 wb_hit;

    always_comb begin
        one_vec = '0;
        for (int r = 0; r < GPR_COUNT; r++) begin
            one_vec[r] = (count[r] == CW'(1));
        end
    end

    // A source hazard only disappears if this write-back is the last one
    // outstanding; saturation on D is relieved by any write-back to D since
    // the accept and retire then cancel in the counter.
    assign wb_hit    = sb.writeback_valid & wbk.tracked;
    assign relieve_a = wb_hit & (wbk.index == src_a.index) & one_vec[src_a.index];
    assign relieve_b = wb_hit & (wbk.index == src_b.index) & one_vec[src_b.index];
    assign relieve_d = wb_hit & (wbk.index == dst.index);
`else
    assign relieve_a = 1'b0;
    assign relieve_b = 1'b0;
    assign relieve_d = 1'b0;
`endif

    assign hazard = (src_a.tracked & nonzero_vec[src_a.index] & ~relieve_a)
                  | (src_b.tracked & nonzero_vec[src_b.index] & ~relieve_b)
                  | (dst.tracked   & sat_vec[dst.index]       & ~relieve_d);

    assign sb.issue_ready = sb.issue_valid & ~hazard & ~flush;
    assign accept         = sb.issue_valid & sb.issue_ready;

    // Write-backs arriving during flush are dropped entirely, so they can
    // neither decrement nor raise underflow.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < GPR_COUNT; r++) begin
            inc_vec[r] = accept & dst.tracked & (dst.index == 4'(r));
            dec_vec[r] = sb.writeback_valid & ~flush & wbk.tracked & (wbk.index == 4'(r));
        end
    end

    for (genvar r = 0; r < GPR_COUNT; r++) begin : g_counter
        gpr_pending_counter #(
            .MAX_INFLIGHT (MAX_INFLIGHT),
            .CW           (CW)
        ) u_counter (
            .clock     (clock),
            .reset_n   (reset_n),
            .clear     (flush),
            .inc       (inc_vec[r]),
            .dec       (dec_vec[r]),
            .count     (count[r]),
            .underflow (uf_vec[r])
        );
    end

    assign underflow_error_d = underflow_error_q | (|uf_vec);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_error_q <= 1'b0;
        end else begin
            underflow_error_q <= underflow_error_d;
        end
    end

    assign busy            = nonzero_vec;
    assign underflow_error = underflow_error_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// tb/tb_gpr_scoreboard.sv - self-checking bench for gpr_scoreboard against a counter-array model

module tb_gpr_scoreboard;
    import package_gpr_source_selector::*;
    import package_gpr_destination_selector::*;

    localparam int MAX = 3;
`ifdef GPR_SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [11:0] busy;
    logic        underflow_error;

    gpr_scoreboard_if sb_if();

    gpr_scoreboard #(.MAX_INFLIGHT(MAX)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .sb              (sb_if.slave),
        .flush           (flush),
        .busy            (busy),
        .underflow_error (underflow_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int pend [12];
    bit uf_m;
    bit last_ready;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_tracked(input int s);
        return (s >= 0) && (s < 12);
    endfunction

    function automatic bit model_ready(input int iv, input int d, input int a, input int b,
                                       input int wbv, input int wbd, input int fl);
        bit haz;
        bit wb_ok;
        if (iv == 0 || fl != 0) return 1'b0;
        wb_ok = (wbv != 0) && is_tracked(wbd);
        haz = 1'b0;
        if (is_tracked(a) && pend[a] != 0 && !(BYPASS && wb_ok && wbd == a && pend[a] == 1)) haz = 1'b1;
        if (is_tracked(b) && pend[b] != 0 && !(BYPASS && wb_ok && wbd == b && pend[b] == 1)) haz = 1'b1;
        if (is_tracked(d) && pend[d] == MAX && !(BYPASS && wb_ok && wbd == d)) haz = 1'b1;
        return !haz;
    endfunction

    task automatic model_update(input bit acc, input int d, input int wbv, input int wbd, input int fl);
        bit inc;
        bit dec;
        if (fl != 0) begin
            foreach (pend[i]) pend[i] = 0;
            return;
        end
        inc = acc && is_tracked(d);
        dec = (wbv != 0) && is_tracked(wbd);
        if (dec && pend[wbd] == 0) uf_m = 1'b1;
        if (inc && dec && d == wbd) return;
        if (inc) pend[d]++;
        if (dec && pend[wbd] > 0) pend[wbd]--;
    endtask

    function automatic logic [11:0] model_busy();
        logic [11:0] v = '0;
        for (int i = 0; i < 12; i++) v[i] = (pend[i] != 0);
        return v;
    endfunction

    // Entered 1 time unit after a rising edge; leaves at the same phase.
    task automatic step(input int iv, input int d, input int a, input int b,
                        input int wbv, input int wbd, input int fl);
        bit exp_r;
        logic [3:0] d4, a4, b4, w4;
        d4 = d[3:0]; a4 = a[3:0]; b4 = b[3:0]; w4 = wbd[3:0];
        sb_if.issue_valid           = iv[0];
        sb_if.issue_destination     = GPR_DESTINATION_SELECTOR'(d4);
        sb_if.issue_source_a        = GPR_SOURCE_SELECTOR'(a4);
        sb_if.issue_source_b        = GPR_SOURCE_SELECTOR'(b4);
        sb_if.writeback_valid       = wbv[0];
        sb_if.writeback_destination = GPR_DESTINATION_SELECTOR'(w4);
        flush                       = fl[0];
        #1;
        exp_r      = model_ready(iv, d, a, b, wbv, wbd, fl);
        last_ready = sb_if.issue_ready;
        check_eq("issue_ready", 32'(last_ready), 32'(exp_r));
        @(posedge clock);
        model_update(iv != 0 && exp_r, d, wbv, wbd, fl);
        #1;
        check_eq("busy", 32'(busy), 32'(model_busy()));
        check_eq("underflow_error", 32'(underflow_error), 32'(uf_m));
    endtask

    // Asserts reset between edges and checks the clear happens without a clock.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        foreach (pend[i]) pend[i] = 0;
        uf_m = 1'b0;
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_underflow", 32'(underflow_error), 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int d, a, b, wbd, iv, wbv, fl;
        sb_if.issue_valid           = 1'b0;
        sb_if.issue_destination     = DST_NONE;
        sb_if.issue_source_a        = SRC_NONE;
        sb_if.issue_source_b        = SRC_NONE;
        sb_if.writeback_valid       = 1'b0;
        sb_if.writeback_destination = DST_NONE;
        foreach (pend[i]) pend[i] = 0;
        uf_m = 1'b0;
        #1;
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_underflow", 32'(underflow_error), 32'h0);
        check_eq("reset_ready_idle", 32'(sb_if.issue_ready), 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // RAW on GPR3
        step(1, 3, 15, 15, 0, 0, 0);
        check_eq("first_accept", 32'(last_ready), 32'h1);
        check_eq("busy_gpr3", 32'(busy), 32'h008);
        step(1, 15, 3, 15, 0, 0, 0);
        check_eq("raw_hold", 32'(last_ready), 32'h0);
        step(1, 15, 3, 15, 1, 3, 0);
        check_eq("raw_wb_cycle", 32'(last_ready), 32'(BYPASS));
        step(1, 15, 14, 3, 0, 0, 0);
        check_eq("raw_after_wb", 32'(last_ready), 32'h1);

        // Saturation on RB
        for (int i = 0; i < 3; i++) step(1, 10, 15, 15, 0, 0, 0);
        step(1, 10, 15, 15, 0, 0, 0);
        check_eq("rb_saturated", 32'(last_ready), 32'h0);
        step(1, 10, 15, 15, 1, 10, 0);
        check_eq("rb_wb_cycle", 32'(last_ready), 32'(BYPASS));
        step(1, 10, 15, 15, 0, 0, 0);
        check_eq("rb_released", 32'(last_ready), 32'(!BYPASS));
        step(1, 2, 15, 15, 0, 0, 1);
        check_eq("flush_blocks", 32'(last_ready), 32'h0);

        // Same-cycle accept and write-back on GPR1
        step(1, 1, 15, 15, 0, 0, 0);
        step(1, 1, 15, 15, 1, 1, 0);
        check_eq("same_cycle_ready", 32'(last_ready), 32'h1);
        check_eq("same_cycle_busy1", 32'(busy[1]), 32'h1);
        step(0, 15, 15, 15, 1, 1, 0);
        check_eq("gpr1_drained", 32'(busy), 32'h0);

        // Underflow on RAP is sticky through flush
        step(0, 15, 15, 15, 1, 9, 0);
        check_eq("underflow_set", 32'(underflow_error), 32'h1);
        step(0, 15, 15, 15, 0, 0, 1);
        check_eq("underflow_sticky", 32'(underflow_error), 32'h1);

        // Write-back during flush never raises underflow
        do_reset();
        step(0, 15, 15, 15, 1, 5, 1);
        check_eq("flush_wb_ignored", 32'(underflow_error), 32'h0);

        // Five pending writes then flush
        step(1, 0, 15, 15, 0, 0, 0);
        step(1, 0, 15, 15, 0, 0, 0);
        step(1, 8, 15, 15, 0, 0, 0);
        step(1, 8, 15, 15, 0, 0, 0);
        step(1, 11, 15, 15, 0, 0, 0);
        check_eq("five_pending", 32'(busy), 32'h901);
        step(1, 2, 15, 15, 0, 0, 1);
        check_eq("flush_issue_blocked", 32'(last_ready), 32'h0);
        check_eq("flush_clears", 32'(busy), 32'h0);

        // Mid-sequence asynchronous reset
        step(1, 4, 15, 15, 0, 0, 0);
        step(1, 5, 15, 15, 1, 6, 0);
        do_reset();

        // Randomized traffic, concentrated on a few registers to provoke hazards
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) do_reset();
            iv  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            wbv = ($urandom_range(0, 9) < 4) ? 1 : 0;
            wbd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 39) == 0) ? 1 : 0;
            step(iv, d, a, b, wbv, wbd, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
